fp_unpack_pipe: RTL and testbench
=================================

# fp_unpack_pipe

Parametrised, pipelined IEEE-754-style floating-point unpacker with a valid/ready handshake and a two-entry skid buffer. It splits each operand into sign, effective exponent and mantissa with the hidden bit resolved, and classifies the operand as zero, subnormal, infinity or NaN. It sits at the front of the FP datapath, feeding the operand alignment and arithmetic stages. It sustains one operand per cycle under continuous `out_ready`.

## Interface
- `EXP_W`, default 8: exponent field width; must be ≥ 2.
- `MAN_W`, default 23: stored fraction width; must be ≥ 1. Total word width W = 1+EXP_W+MAN_W.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `float_in`  in  W  packed operand: sign [W-1], exponent [W-2:MAN_W], fraction [MAN_W-1:0].
- `in_valid`  in  1  `float_in` is valid.
- `in_ready`  out  1  block can accept; a transfer occurs when `in_valid && in_ready`.
- `out_valid`  out  1  output fields are valid.
- `out_ready`  in  1  consumer accepts; a transfer occurs when `out_valid && out_ready`.
- `sign`  out  1  operand sign.
- `exponent`  out  EXP_W  effective biased exponent.
- `mantissa`  out  MAN_W+1  {hidden bit, fraction}.
- `is_zero`, `is_denorm`, `is_inf`, `is_nan`  out  1 each  class flags; at most one is set.

## Operation
- Decode is combinational on `float_in` and registered on acceptance.
- Exponent field E, fraction F:
  - E=0, F=0: zero. Hidden bit is 0; `exponent` = 0; `is_zero`=1.
  - E=0, F≠0: subnormal. Hidden bit is 0; `exponent` = 1 (the effective exponent); `is_denorm`=1.
  - E all-ones, F=0: infinity. `is_inf`=1; hidden bit is 1; `exponent` = E.
  - E all-ones, F≠0: NaN. `is_nan`=1; hidden bit is 1; `exponent` = E; fraction is passed through unchanged.
  - Otherwise: normal. Hidden bit is 1; `exponent` = E; no flag is set.
- `sign` always equals the input sign bit, including for zero and NaN.
- Storage is an output register (OUT) plus a skid register (SKID). `count` is in {0,1,2}.
  - `count`=0: OUT empty. An accepted input loads OUT, and `count` goes to 1.
  - `count`=1: OUT holds data.
    - Input accepted and output taken: OUT reloads with the new input; `count` stays 1.
    - Input accepted, output not taken: the new input goes to SKID; `count` goes to 2.
    - Output taken, no input: `count` goes to 0.
  - `count`=2: OUT and SKID are both full; no input is accepted. When the output is taken, SKID moves to OUT and `count` goes to 1.
- `in_ready` = (`count` != 2), driven from registered state only; there is no combinational path from `out_ready`.
- `out_valid` = (`count` != 0).
- OUT contents are stable while `out_valid && !out_ready`.
- Data order is strictly FIFO; no operand is dropped or duplicated.

## Timing
- Latency: an operand accepted on edge N appears on the outputs after edge N, provided OUT was empty or drained on the same edge.
- Throughput is 1 operand/cycle while `out_ready` is held high.
- Reset (async assert, sync-to-`clk` deassert handled upstream):
  - `count`=0, `out_valid`=0, `in_ready`=1.
  - `sign`, `exponent`, `mantissa` and all flags are 0.
  - SKID is cleared.
- Reset mid-operation discards both entries immediately. The first acceptance after release takes the normal path.
- `in_ready` falls on the edge after the SKID fill. It rises on the edge after the SKID drain.
- `in_valid` while `in_ready`=0 has no effect. The source holds its data; the block neither samples nor latches it.

## Configuration
- `FP_UNPACK_FLUSH_DENORM_EN`:
  - Defined: a subnormal input is reported as a signed zero. `exponent`=0, `mantissa`=0, `is_zero`=1, `is_denorm`=0, and `sign` is kept.
  - Undefined: subnormals are handled as in Operation (`is_denorm`=1, `exponent`=1, fraction kept).

## Test plan
- Values use defaults, `out_ready`=1.
- 0x3F800000 → sign 0, exponent 0x7F, mantissa 0x800000, no flags, `out_valid` one cycle after acceptance.
- 0x80000000 → sign 1, exponent 0, mantissa 0, `is_zero`. 0xFF800000 → sign 1, exponent 0xFF, mantissa 0x800000, `is_inf`. 0x7FC00001 → `is_nan`, mantissa 0xC00001.
- 0x00000001:
  - Macro undefined → `is_denorm`, exponent 1, mantissa 0x000001.
  - Macro defined → `is_zero`, mantissa 0, sign 0.
- Backpressure: stream A, B, C back-to-back with `out_ready`=0.
  - `in_ready` falls after B is accepted, and C is held off.
  - Raise `out_ready`: outputs A, B, C in order, one per cycle; `in_ready` rises after SKID drains.
- Reset mid-operation: assert `rst_n`=0 with `count`=2.
  - `out_valid`=0 and `in_ready`=1 immediately, all outputs 0.
  - After release, the next operand emerges with 1-cycle latency.
- Random stream with random `out_ready`, swept across (`EXP_W`,`MAN_W`) = (5,10), (8,23), (11,52): scoreboard matches a reference decode, with no loss, duplication or reordering.

Source files
------------

// File: rtl/fp_unpack_pipe.sv
// fp_unpack_pipe: IEEE-754-style operand unpacker with a valid/ready
// handshake, an output register and a one-entry skid register.
//
// Parameters: EXP_W exponent width (>=2), MAN_W stored fraction width (>=1).
// Ports:
//   clk, rst_n          clock, async active-low reset
//   float_in, in_valid  packed operand and its valid
//   in_ready            accept strobe (registered state only)
//   out_valid/out_ready output handshake
//   sign, exponent      sign and effective biased exponent
//   mantissa            {hidden bit, fraction}
//   is_zero/is_denorm/is_inf/is_nan  class flags (one-hot or none)
// Build option: FP_UNPACK_FLUSH_DENORM_EN reports subnormals as signed zero.

module fp_unpack_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [EXP_W+MAN_W:0] float_in,
   input  logic               in_valid,
   output logic               in_ready,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               sign,
   output logic [EXP_W-1:0]   exponent,
   output logic [MAN_W:0]     mantissa,
   output logic               is_zero,
   output logic               is_denorm,
   output logic               is_inf,
   output logic               is_nan
);

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] expo;
      logic [MAN_W:0]   man;
      logic             zero;
      logic             denorm;
      logic             inf;
      logic             nan;
   } rec_t;

   rec_t             dec;
   rec_t             outReg;
   rec_t             skidReg;
   logic [1:0]       count;
   logic [EXP_W-1:0] expField;
   logic [MAN_W-1:0] fracField;
   logic             expZero;
   logic             expOnes;
   logic             fracZero;
   logic             accept;
   logic             take;

   assign expField  = float_in[EXP_W+MAN_W-1:MAN_W];
   assign fracField = float_in[MAN_W-1:0];
   assign expZero   = (expField == '0);
   assign expOnes   = &expField;
   assign fracZero  = (fracField == '0);

   always_comb begin
      dec      = '0;
      dec.sign = float_in[EXP_W+MAN_W];
      unique case (1'b1)
         (expZero && fracZero): begin
            dec.zero = 1'b1;
         end
         (expZero && !fracZero): begin
`ifdef FP_UNPACK_FLUSH_DENORM_EN
            dec.zero = 1'b1;
`else
            // Subnormals share the scale of exponent 1.
            dec.expo   = EXP_W'(1);
            dec.man    = {1'b0, fracField};
            dec.denorm = 1'b1;
`endif
         end
         default: begin
            dec.expo = expField;
            dec.man  = {1'b1, fracField};
            dec.inf  = expOnes && fracZero;
            dec.nan  = expOnes && !fracZero;
         end
      endcase
   end

   // in_ready depends only on count, so out_ready never reaches it.
   assign in_ready  = (count != 2'd2);
   assign out_valid = (count != 2'd0);
   assign accept    = in_valid && in_ready;
   assign take      = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count   <= 2'd0;
         outReg  <= '0;
         skidReg <= '0;
      end else begin
         case (count)
            2'd0: begin
               if (accept) begin
                  outReg <= dec;
                  count  <= 2'd1;
               end
            end
            2'd1: begin
               if (accept && take) begin
                  outReg <= dec;
               end else if (accept) begin
                  skidReg <= dec;
                  count   <= 2'd2;
               end else if (take) begin
                  count <= 2'd0;
               end
            end
            2'd2: begin
               if (take) begin
                  outReg <= skidReg;
                  count  <= 2'd1;
               end
            end
            default: count <= 2'd0;
         endcase
      end
   end

   assign sign      = outReg.sign;
   assign exponent  = outReg.expo;
   assign mantissa  = outReg.man;
   assign is_zero   = outReg.zero;
   assign is_denorm = outReg.denorm;
   assign is_inf    = outReg.inf;
   assign is_nan    = outReg.nan;

endmodule

// File: tb/tb_fp_unpack_pipe.sv
// tb_fp_unpack_pipe: directed vectors, handshake sequences and a
// randomized scoreboard over three (EXP_W, MAN_W) configurations.

module tb_fp_unpack_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic [2:0][63:0] fin;
   logic [2:0]       inV;
   logic [2:0]       oR;
   logic [2:0]       oInRdy;
   logic [2:0]       oOutV;
   logic [2:0]       oSign;
   logic [2:0][15:0] oExp;
   logic [2:0][63:0] oMan;
   logic [2:0][3:0]  oFl;

   int checks = 0;
   int errors = 0;

   for (genvar g = 0; g < 3; g++) begin : cfg
      localparam int EW = (g == 0) ? 5 : ((g == 1) ? 8 : 11);
      localparam int MW = (g == 0) ? 10 : ((g == 1) ? 23 : 52);
      localparam int W  = 1 + EW + MW;
      logic          s, z, d, inf, n, iR, oV;
      logic [EW-1:0] e;
      logic [MW:0]   m;
      fp_unpack_pipe #(.EXP_W(EW), .MAN_W(MW)) u (
         .clk(clk), .rst_n(rst_n),
         .float_in(fin[g][W-1:0]), .in_valid(inV[g]),
         .in_ready(iR), .out_valid(oV), .out_ready(oR[g]),
         .sign(s), .exponent(e), .mantissa(m),
         .is_zero(z), .is_denorm(d), .is_inf(inf), .is_nan(n)
      );
      assign oSign[g]  = s;
      assign oExp[g]   = 16'(e);
      assign oMan[g]   = 64'(m);
      assign oFl[g]    = {z, d, inf, n};
      assign oInRdy[g] = iR;
      assign oOutV[g]  = oV;
   end

   function automatic int cfgEw(int c);
      return (c == 0) ? 5 : ((c == 1) ? 8 : 11);
   endfunction

   function automatic int cfgMw(int c);
      return (c == 0) ? 10 : ((c == 1) ? 23 : 52);
   endfunction

   // Reference decode from the field rules, flags ordered {zero,denorm,inf,nan}.
   function automatic void refDec(input int ew, input int mw,
                                  input logic [63:0] x,
                                  output logic s, output logic [15:0] e,
                                  output logic [63:0] m, output logic [3:0] fl);
      longint unsigned fmask = (64'd1 << mw) - 1;
      longint unsigned emax  = (64'd1 << ew) - 1;
      longint unsigned f     = x & fmask;
      longint unsigned ef    = (x >> mw) & emax;
      s = x[ew + mw];
      if (ef == 0 && f == 0) begin
         e = 0; m = 0; fl = 4'b1000;
      end else if (ef == 0) begin
`ifdef FP_UNPACK_FLUSH_DENORM_EN
         e = 0; m = 0; fl = 4'b1000;
`else
         e = 1; m = f; fl = 4'b0100;
`endif
      end else begin
         e = 16'(ef);
         m = (64'd1 << mw) + f;
         if (ef == emax) fl = (f == 0) ? 4'b0010 : 4'b0001;
         else fl = 4'b0000;
      end
   endfunction

   function automatic logic [63:0] randOp(int c);
      int ew = cfgEw(c);
      int mw = cfgMw(c);
      longint unsigned emax = (64'd1 << ew) - 1;
      longint unsigned ef;
      longint unsigned f = {$urandom, $urandom};
      int kind = int'($urandom % 5);
      f = f & ((64'd1 << mw) - 1);
      if (kind == 0) ef = 0;
      else if (kind == 1) ef = emax;
      else ef = longint'($urandom_range(1, 32'(emax - 1)));
      if (kind < 2 && ($urandom % 2) == 0) f = 0;
      return (64'($urandom % 2) << (ew + mw)) | (ef << mw) | f;
   endfunction

   task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, req);
      end
   endtask

   task automatic outChk(int c, logic [63:0] x);
      logic s;
      logic [15:0] e;
      logic [63:0] m;
      logic [3:0] fl;
      refDec(cfgEw(c), cfgMw(c), x, s, e, m, fl);
      chk($sformatf("rnd_c%0d_sign", c), 64'(oSign[c]), 64'(s));
      chk($sformatf("rnd_c%0d_exp", c), 64'(oExp[c]), 64'(e));
      chk($sformatf("rnd_c%0d_man", c), oMan[c], m);
      chk($sformatf("rnd_c%0d_flags", c), 64'(oFl[c]), 64'(fl));
   endtask

   typedef struct {
      logic [31:0] x;
      logic        s;
      logic [7:0]  e;
      logic [23:0] m;
      logic [3:0]  fl;
   } vec_t;

   vec_t vecs[9];

   initial begin
      logic [63:0] q[$];
      logic [63:0] x;
      bit pending;
      bit acc;

      vecs[0] = '{32'h3F800000, 1'b0, 8'h7F, 24'h800000, 4'b0000};
      vecs[1] = '{32'h80000000, 1'b1, 8'h00, 24'h000000, 4'b1000};
      vecs[2] = '{32'hFF800000, 1'b1, 8'hFF, 24'h800000, 4'b0010};
      vecs[3] = '{32'h7FC00001, 1'b0, 8'hFF, 24'hC00001, 4'b0001};
`ifdef FP_UNPACK_FLUSH_DENORM_EN
      vecs[4] = '{32'h00000001, 1'b0, 8'h00, 24'h000000, 4'b1000};
      vecs[5] = '{32'h807FFFFF, 1'b1, 8'h00, 24'h000000, 4'b1000};
`else
      vecs[4] = '{32'h00000001, 1'b0, 8'h01, 24'h000001, 4'b0100};
      vecs[5] = '{32'h807FFFFF, 1'b1, 8'h01, 24'h7FFFFF, 4'b0100};
`endif
      vecs[6] = '{32'h7F7FFFFF, 1'b0, 8'hFE, 24'hFFFFFF, 4'b0000};
      vecs[7] = '{32'h00800000, 1'b0, 8'h01, 24'h800000, 4'b0000};
      vecs[8] = '{32'h7F800001, 1'b0, 8'hFF, 24'h800001, 4'b0001};

      rst_n = 1'b0;
      fin   = '0;
      inV   = '0;
      oR    = '0;
      #12;
      for (int c = 0; c < 3; c++) begin
         chk("rst_out_valid", 64'(oOutV[c]), 64'd0);
         chk("rst_in_ready", 64'(oInRdy[c]), 64'd1);
         chk("rst_fields", {oExp[c], 47'd0, oSign[c]} | oMan[c], 64'd0);
         chk("rst_flags", 64'(oFl[c]), 64'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      oR[1] = 1'b1;
      for (int i = 0; i < 9; i++) begin
         fin[1] = 64'(vecs[i].x);
         inV[1] = 1'b1;
         @(negedge clk);
         chk("vec_in_ready", 64'(oInRdy[1]), 64'd1);
         @(posedge clk); #1;
         inV[1] = 1'b0;
         @(negedge clk);
         chk("vec_out_valid", 64'(oOutV[1]), 64'd1);
         chk("vec_sign", 64'(oSign[1]), 64'(vecs[i].s));
         chk("vec_exp", 64'(oExp[1]), 64'(vecs[i].e));
         chk("vec_man", oMan[1], 64'(vecs[i].m));
         chk("vec_flags", 64'(oFl[1]), 64'(vecs[i].fl));
         @(posedge clk); #1;
      end

      // Backpressure: A, B fill OUT and SKID; C must wait.
      oR[1]  = 1'b0;
      fin[1] = 64'h3F800000;
      inV[1] = 1'b1;
      @(posedge clk); #1;
      fin[1] = 64'h40000000;
      @(posedge clk); #1;
      fin[1] = 64'h40400000;
      @(negedge clk);
      chk("bp_in_ready_low", 64'(oInRdy[1]), 64'd0);
      chk("bp_A", {oExp[1][7:0], oMan[1][23:0]}, 64'h7F800000);
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_hold_ready", 64'(oInRdy[1]), 64'd0);
      chk("bp_A_stable", {oExp[1][7:0], oMan[1][23:0]}, 64'h7F800000);
      oR[1] = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_B", {oExp[1][7:0], oMan[1][23:0]}, 64'h80800000);
      chk("bp_in_ready_rise", 64'(oInRdy[1]), 64'd1);
      @(posedge clk); #1;
      inV[1] = 1'b0;
      @(negedge clk);
      chk("bp_C", {oExp[1][7:0], oMan[1][23:0]}, 64'h80C00000);
      chk("bp_C_valid", 64'(oOutV[1]), 64'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_empty", 64'(oOutV[1]), 64'd0);
      @(posedge clk); #1;

      // Reset with both entries full.
      oR[1]  = 1'b0;
      fin[1] = 64'h3F800000;
      inV[1] = 1'b1;
      @(posedge clk); #1;
      fin[1] = 64'h40000000;
      @(posedge clk); #1;
      inV[1] = 1'b0;
      @(negedge clk);
      chk("mid_full", 64'(oInRdy[1]), 64'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(oOutV[1]), 64'd0);
      chk("mid_rst_ready", 64'(oInRdy[1]), 64'd1);
      chk("mid_rst_fields", {oExp[1], 47'd0, oSign[1]} | oMan[1], 64'd0);
      chk("mid_rst_flags", 64'(oFl[1]), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      fin[1] = 64'hC0490FDB;
      inV[1] = 1'b1;
      oR[1]  = 1'b1;
      @(posedge clk); #1;
      inV[1] = 1'b0;
      @(negedge clk);
      chk("post_rst_valid", 64'(oOutV[1]), 64'd1);
      chk("post_rst_data", {oSign[1], oExp[1][7:0], oMan[1][23:0]},
          64'h1_80C90FDB);
      @(posedge clk); #1;

      for (int c = 0; c < 3; c++) begin
         q.delete();
         pending = 1'b0;
         for (int cyc = 0; cyc < 500; cyc++) begin
            if (!pending) begin
               inV[c] = ($urandom % 4) != 0;
               fin[c] = randOp(c);
            end
            oR[c] = ($urandom % 3) != 0;
            @(negedge clk);
            chk("rnd_out_valid", 64'(oOutV[c]), 64'(q.size() != 0));
            chk("rnd_in_ready", 64'(oInRdy[c]), 64'(q.size() < 2));
            if (oOutV[c] && oR[c] && q.size() != 0) begin
               x = q.pop_front();
               outChk(c, x);
            end
            acc = inV[c] && oInRdy[c];
            if (acc) q.push_back(fin[c]);
            pending = inV[c] && !acc;
            @(posedge clk); #1;
         end
         inV[c] = 1'b0;
         oR[c]  = 1'b1;
         for (int k = 0; k < 10 && q.size() != 0; k++) begin
            @(negedge clk);
            if (oOutV[c]) begin
               x = q.pop_front();
               outChk(c, x);
            end
            @(posedge clk); #1;
         end
         chk("rnd_drain_left", 64'(q.size()), 64'd0);
         @(negedge clk);
         chk("rnd_drain_valid", 64'(oOutV[c]), 64'd0);
         @(posedge clk); #1;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
